// File: rtl/adc_spi_reader_pkg.sv
// Shared ADC frame definitions: frame width and channel packing (channel A in the high half).
// The DAC writer uses the same packing.
package adc_spi_reader_pkg;

  localparam int ADC_FRAME_BITS = 32;
  localparam int ADC_CH_BITS    = ADC_FRAME_BITS / 2;

  typedef struct packed {
    logic [ADC_CH_BITS-1:0] ch_a;
    logic [ADC_CH_BITS-1:0] ch_b;
  } adc_sample_t;

  function automatic adc_sample_t adc_pack(input logic [ADC_CH_BITS-1:0] a,
                                           input logic [ADC_CH_BITS-1:0] b);
    adc_sample_t s;
    s.ch_a = a;
    s.ch_b = b;
    return s;
  endfunction

endpackage

// File: rtl/adc_spi_reader.sv
// Periodic SPI read master for a dual-channel simultaneous-sampling ADC.
// Fires CNV every SAMPLE_PERIOD cycles, reads 32 bits, and presents them as one valid/ready word.
module adc_spi_reader
  import adc_spi_reader_pkg::*;
#(
  parameter int CONV_CYCLES   = 30,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  output logic [ADC_FRAME_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      overflow,
  output logic                      cnv,
  output logic                      cs,
  output logic                      sclk,
  input  logic                      sdo
);

  localparam int READ_LAST_I = 2 * ADC_FRAME_BITS - 1;
  localparam int CNT_W       = ($clog2(CONV_CYCLES) > $clog2(2 * ADC_FRAME_BITS)) ?
                               $clog2(CONV_CYCLES) : $clog2(2 * ADC_FRAME_BITS);
  localparam int PER_W       = $clog2(SAMPLE_PERIOD);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_LAST_I);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);

  if (CONV_CYCLES < 1) begin : g_bad_conv
    $error("adc_spi_reader: CONV_CYCLES must be at least 1");
  end
  if (SAMPLE_PERIOD < CONV_CYCLES + 66) begin : g_bad_period
    $error("adc_spi_reader: SAMPLE_PERIOD must be at least CONV_CYCLES + 66");
  end

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READ,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PER_W-1:0]          per_q, per_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic [ADC_FRAME_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      overflow_q, overflow_d;
  logic                      cnv_q, cnv_d;
  logic                      cs_q, cs_d;
  logic                      sclk_q, sclk_d;
  logic                      tick;

  always_comb begin
    per_d      = per_q;
    tick       = enable && (per_q == '0);
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnv_d      = cnv_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    shift_d    = shift_q;
    data_d     = data_q;
    overflow_d = 1'b0;
    valid_d    = valid_q && !ready;

    if (!enable || per_q == PER_LAST) begin
      per_d = '0;
    end else begin
      per_d = per_q + PER_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CONVERT;
          cnv_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        if (cnt_q == CONV_LAST) begin
          cnv_d   = 1'b0;
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        // Odd counts are the edges where sclk registers high: the ADC's rising edge.
        sclk_d = cnt_q[0];
        if (cnt_q[0]) begin
          shift_d = {shift_q[ADC_FRAME_BITS-2:0], sdo};
        end
        if (cnt_q == READ_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        state_d = IDLE;
        // A word being accepted this cycle frees the slot for the new sample.
        if (!valid_q || ready) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      cnv_q      <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      cnv_q      <= cnv_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign cnv      = cnv_q;
  assign cs       = cs_q;
  assign sclk     = sclk_q;

endmodule
